// File: rtl/divisor_buffer_pkg.sv
// -----------------------------------------------------------------------------
// divisor_buffer_pkg
// Shared SPART constants: I/O addresses of the two baud-divisor bytes and the
// divisor / byte widths used by the divisor capture buffer.
// -----------------------------------------------------------------------------
package divisor_buffer_pkg;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned BYTE_W = 8;

  // I/O register map of the divisor bytes (DB low / DB high)
  localparam logic [1:0] SPART_ADDR_DB_LO = 2'b10;
  localparam logic [1:0] SPART_ADDR_DB_HI = 2'b11;

  // Divisor value loaded on reset
  localparam logic [DIV_W-1:0] SPART_RESET_DIV = '0;

endpackage : divisor_buffer_pkg

// File: rtl/divisor_buffer_byte_stage.sv
// -----------------------------------------------------------------------------
// divisor_buffer_byte_stage
// One staged divisor byte: an 8-bit holding register plus a valid flag.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-low reset (clears data and flag)
//   i_load  : load i_data into the register and set the flag
//   i_clr   : clear the flag (wins over i_load for the flag only)
//   i_data  : byte to stage
//   o_data  : staged byte
//   o_vld   : staged byte is waiting for its partner
// -----------------------------------------------------------------------------
module divisor_buffer_byte_stage
  import divisor_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [BYTE_W-1:0] i_data,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_vld
);

  logic [BYTE_W-1:0] r_data;
  logic              r_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
      end
      // A commit clears the flag even when this byte is the one being
      // written on the committing cycle.
      if (i_clr) begin
        r_vld <= 1'b0;
      end else if (i_load) begin
        r_vld <= 1'b1;
      end
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld;

endmodule : divisor_buffer_byte_stage

// File: rtl/divisor_buffer.sv
// -----------------------------------------------------------------------------
// divisor_buffer
// Captures the 16-bit UART baud divisor written as two bytes and commits both
// bytes together onto div_buf, pulsing buf_rdy for one cycle on each commit.
// Byte order is free; the second distinct byte written completes the pair.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-low reset
//   io_addr    : I/O register address from the bus interface
//   baud_write : write strobe qualifying io_addr / data_in
//   data_in    : write data byte
//   div_buf    : committed divisor {high, low} (registered)
//   buf_rdy    : one-cycle pulse after a commit (registered)
// -----------------------------------------------------------------------------
module divisor_buffer
  import divisor_buffer_pkg::*;
#(
  parameter logic [1:0]       ADDR_LO   = SPART_ADDR_DB_LO,
  parameter logic [1:0]       ADDR_HI   = SPART_ADDR_DB_HI,
  parameter logic [DIV_W-1:0] RESET_DIV = SPART_RESET_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        io_addr,
  input  logic              baud_write,
  input  logic [BYTE_W-1:0] data_in,
  output logic [DIV_W-1:0]  div_buf,
  output logic              buf_rdy
);

  logic              w_wr_lo;
  logic              w_wr_hi;
  logic              w_commit;
  logic [BYTE_W-1:0] w_lo_data;
  logic [BYTE_W-1:0] w_hi_data;
  logic              w_lo_vld;
  logic              w_hi_vld;
  logic [BYTE_W-1:0] w_lo_byte;
  logic [BYTE_W-1:0] w_hi_byte;

  logic [DIV_W-1:0]  r_div_buf;
  logic              r_buf_rdy;

  // Address decode; any other address is ignored.
  assign w_wr_lo = baud_write && (io_addr == ADDR_LO);
  assign w_wr_hi = baud_write && (io_addr == ADDR_HI);

  // The pair completes when this write supplies the byte whose partner is
  // already staged. Rewriting an already-staged byte alone never commits.
  assign w_commit = (w_wr_lo && w_hi_vld) || (w_wr_hi && w_lo_vld);

  // The byte being written this cycle bypasses its stage register.
  assign w_lo_byte = w_wr_lo ? data_in : w_lo_data;
  assign w_hi_byte = w_wr_hi ? data_in : w_hi_data;

  divisor_buffer_byte_stage u_lo_stage (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_wr_lo),
    .i_clr  (w_commit),
    .i_data (data_in),
    .o_data (w_lo_data),
    .o_vld  (w_lo_vld)
  );

  divisor_buffer_byte_stage u_hi_stage (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_wr_hi),
    .i_clr  (w_commit),
    .i_data (data_in),
    .o_data (w_hi_data),
    .o_vld  (w_hi_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_buf <= RESET_DIV;
      r_buf_rdy <= 1'b0;
    end else begin
      r_buf_rdy <= w_commit;
      if (w_commit) begin
        r_div_buf <= {w_hi_byte, w_lo_byte};
      end
    end
  end

  assign div_buf = r_div_buf;
  assign buf_rdy = r_buf_rdy;

endmodule : divisor_buffer

// File: tb/tb_divisor_buffer.sv
// -----------------------------------------------------------------------------
// tb_divisor_buffer
// Directed bench for divisor_buffer. Inputs change on the falling edge and
// outputs are sampled on the falling edge that follows each rising edge.
// -----------------------------------------------------------------------------
module tb_divisor_buffer;

  localparam logic [1:0] LO = 2'b10;
  localparam logic [1:0] HI = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  io_addr = 2'b00;
  logic        baud_write = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] div_buf;
  logic        buf_rdy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divisor_buffer #(
    .ADDR_LO   (2'b10),
    .ADDR_HI   (2'b11),
    .RESET_DIV (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_addr    (io_addr),
    .baud_write (baud_write),
    .data_in    (data_in),
    .div_buf    (div_buf),
    .buf_rdy    (buf_rdy)
  );

  // Apply one cycle of inputs (called at a falling edge), clock it, and
  // return at the next falling edge with outputs settled.
  task automatic cyc(input logic w, input logic [1:0] a, input logic [7:0] d,
                     input logic r);
    baud_write = w;
    io_addr    = a;
    data_in    = d;
    rst        = r;
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t rst=%b wr=%b addr=%b data=%h -> div_buf=%h buf_rdy=%b",
             $time, r, w, a, d, div_buf, buf_rdy);
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    cyc(1'b0, 2'b00, 8'h00, 1'b0);
    cyc(1'b0, 2'b00, 8'h00, 1'b0);
    n_cmp++; if (div_buf !== 16'h0000) begin n_err++; $display("FAIL reset_div got %h exp %h", div_buf, 16'h0000); end
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b exp %b", buf_rdy, 1'b0); end
  endtask

  task automatic test_lo_hi();
    cyc(1'b1, LO, 8'hAA, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL lohi_rdy_early got %b exp 0", buf_rdy); end
    n_cmp++; if (div_buf !== 16'h0000) begin n_err++; $display("FAIL lohi_div_early got %h exp 0000", div_buf); end
    cyc(1'b1, HI, 8'h50, 1'b1);
    n_cmp++; if (div_buf !== 16'h50AA) begin n_err++; $display("FAIL lohi_div got %h exp 50aa", div_buf); end
    n_cmp++; if (buf_rdy !== 1'b1) begin n_err++; $display("FAIL lohi_rdy got %b exp 1", buf_rdy); end
    idle();
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL lohi_rdy_drop got %b exp 0", buf_rdy); end
    n_cmp++; if (div_buf !== 16'h50AA) begin n_err++; $display("FAIL lohi_div_hold got %h exp 50aa", div_buf); end
  endtask

  task automatic test_hi_lo();
    cyc(1'b1, HI, 8'h12, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL hilo_rdy_early got %b exp 0", buf_rdy); end
    cyc(1'b1, LO, 8'h34, 1'b1);
    n_cmp++; if (div_buf !== 16'h1234) begin n_err++; $display("FAIL hilo_div got %h exp 1234", div_buf); end
    n_cmp++; if (buf_rdy !== 1'b1) begin n_err++; $display("FAIL hilo_rdy got %b exp 1", buf_rdy); end
    idle();
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL hilo_rdy_drop got %b exp 0", buf_rdy); end
  endtask

  task automatic test_overwrite();
    cyc(1'b1, LO, 8'h0F, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL ovw_rdy1 got %b exp 0", buf_rdy); end
    cyc(1'b1, LO, 8'h50, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL ovw_rdy2 got %b exp 0", buf_rdy); end
    n_cmp++; if (div_buf !== 16'h1234) begin n_err++; $display("FAIL ovw_div_hold got %h exp 1234", div_buf); end
    cyc(1'b1, HI, 8'h00, 1'b1);
    n_cmp++; if (div_buf !== 16'h0050) begin n_err++; $display("FAIL ovw_div got %h exp 0050", div_buf); end
    n_cmp++; if (buf_rdy !== 1'b1) begin n_err++; $display("FAIL ovw_rdy got %b exp 1", buf_rdy); end
    idle();
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL ovw_rdy_drop got %b exp 0", buf_rdy); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, LO, 8'hAA, 1'b1);
    cyc(1'b0, 2'b00, 8'h00, 1'b0);
    n_cmp++; if (div_buf !== 16'h0000) begin n_err++; $display("FAIL rmid_div_rst got %h exp 0000", div_buf); end
    cyc(1'b1, HI, 8'h50, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL rmid_rdy got %b exp 0", buf_rdy); end
    n_cmp++; if (div_buf !== 16'h0000) begin n_err++; $display("FAIL rmid_div got %h exp 0000", div_buf); end
    idle();
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL rmid_rdy_late got %b exp 0", buf_rdy); end
    // hi is staged now; completing with lo must commit the staged hi byte
    cyc(1'b1, LO, 8'h0C, 1'b1);
    n_cmp++; if (div_buf !== 16'h500C) begin n_err++; $display("FAIL rmid_div_done got %h exp 500c", div_buf); end
    idle();
  endtask

  task automatic test_ignored();
    cyc(1'b1, LO, 8'h77, 1'b1);
    cyc(1'b1, HI, 8'h66, 1'b1);
    n_cmp++; if (div_buf !== 16'h6677) begin n_err++; $display("FAIL ign_setup got %h exp 6677", div_buf); end
    cyc(1'b1, 2'b00, 8'h11, 1'b1);
    cyc(1'b1, 2'b01, 8'h22, 1'b1);
    cyc(1'b0, LO,    8'h33, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL ign_rdy got %b exp 0", buf_rdy); end
    cyc(1'b0, HI,    8'h44, 1'b1);
    n_cmp++; if (div_buf !== 16'h6677) begin n_err++; $display("FAIL ign_div got %h exp 6677", div_buf); end
    // nothing may have been staged: a lone high write must not commit
    cyc(1'b1, HI, 8'h55, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL ign_lone_hi got %b exp 0", buf_rdy); end
    cyc(1'b1, LO, 8'h99, 1'b1);
    n_cmp++; if (div_buf !== 16'h5599) begin n_err++; $display("FAIL ign_commit got %h exp 5599", div_buf); end
    idle();
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, LO, 8'h01, 1'b1);
    cyc(1'b1, HI, 8'h02, 1'b1);
    n_cmp++; if (div_buf !== 16'h0201) begin n_err++; $display("FAIL b2b_div1 got %h exp 0201", div_buf); end
    cyc(1'b1, LO, 8'h03, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_rdy_mid got %b exp 0", buf_rdy); end
    cyc(1'b1, HI, 8'h04, 1'b1);
    n_cmp++; if (div_buf !== 16'h0403) begin n_err++; $display("FAIL b2b_div2 got %h exp 0403", div_buf); end
    n_cmp++; if (buf_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy2 got %b exp 1", buf_rdy); end
    idle();
  endtask

  task automatic test_reset_on_commit();
    cyc(1'b1, LO, 8'hAB, 1'b1);
    cyc(1'b1, HI, 8'hCD, 1'b0);
    n_cmp++; if (div_buf !== 16'h0000) begin n_err++; $display("FAIL rcom_div got %h exp 0000", div_buf); end
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL rcom_rdy got %b exp 0", buf_rdy); end
    cyc(1'b1, HI, 8'hEF, 1'b1);
    n_cmp++; if (buf_rdy !== 1'b0) begin n_err++; $display("FAIL rcom_lone_hi got %b exp 0", buf_rdy); end
    idle();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lo_hi();
    test_hi_lo();
    test_overwrite();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    test_reset_on_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_divisor_buffer
